// File: rtl/trap_csr_writer.sv
// rtl/trap_csr_writer.sv - trap entry / mret sequencer driving the machine register write port
module trap_csr_writer #(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_2000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exc_valid_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_cause_i,
    input  logic [31:0] exc_tval_i,
    input  logic        mret_valid_i,
    output logic        req_ready_o,
    output logic        rm_write_enable_o,
    output logic [1:0]  rm_write_addr_o,
    output logic [31:0] rm_write_data_o,
    output logic [1:0]  rm_read_addr_o,
    input  logic [31:0] rm_read_data_i,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_W_EPC    = 3'd1;
    localparam logic [2:0] S_W_CAUSE  = 3'd2;
    localparam logic [2:0] S_W_TVAL   = 3'd3;
    localparam logic [2:0] S_W_PRIV   = 3'd4;
    localparam logic [2:0] S_R_EPC    = 3'd5;
    localparam logic [2:0] S_M_PRIV   = 3'd6;
    localparam logic [2:0] S_REDIRECT = 3'd7;

    localparam logic [1:0]  ADDR_MEPC   = 2'b00;
    localparam logic [1:0]  ADDR_MCAUSE = 2'b01;
    localparam logic [1:0]  ADDR_MTVAL  = 2'b10;
    localparam logic [1:0]  ADDR_PRIV   = 2'b11;
    localparam logic [31:0] PRIV_MACHINE = 32'h0000_0001;
    localparam logic [31:0] PRIV_USER    = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

    logic [2:0]  state_q,  state_d;
    logic [31:0] pc_q,     pc_d;
    logic [31:0] cause_q,  cause_d;
    logic [31:0] tval_q,   tval_d;
    // Fetch target used by REDIRECT: trap vector on entry, restored mepc on mret.
    logic [31:0] target_q, target_d;

    // Next-state and latch update; exception has priority over mret in IDLE.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cause_d  = cause_q;
        tval_d   = tval_q;
        target_d = target_q;
        case (state_q)
            S_IDLE: begin
                if (exc_valid_i || mret_valid_i) begin
                    pc_d    = exc_pc_i;
                    cause_d = exc_cause_i;
                    tval_d  = exc_tval_i;
                end
                if (exc_valid_i) begin
                    state_d  = S_W_EPC;
                    target_d = TRAP_VECTOR;
                end else if (mret_valid_i) begin
                    state_d = S_R_EPC;
                end
            end
            S_W_EPC:   state_d = S_W_CAUSE;
            S_W_CAUSE: state_d = S_W_TVAL;
            S_W_TVAL:  state_d = S_W_PRIV;
            S_W_PRIV:  state_d = S_REDIRECT;
            S_R_EPC: begin
                // The register file read is combinational, so mepc is valid this cycle.
                target_d = rm_read_data_i & ALIGN_MASK;
                state_d  = S_M_PRIV;
            end
            S_M_PRIV:   state_d = S_REDIRECT;
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // State and latch registers with synchronous reset that aborts any sequence.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            pc_q     <= 32'h0;
            cause_q  <= 32'h0;
            tval_q   <= 32'h0;
            target_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cause_q  <= cause_d;
            tval_q   <= tval_d;
            target_q <= target_d;
        end
    end

    assign rm_read_addr_o = ADDR_MEPC;

    // Output decode from registered state only; reset forces every output low.
    always_comb begin
        req_ready_o       = 1'b0;
        rm_write_enable_o = 1'b0;
        rm_write_addr_o   = 2'b00;
        rm_write_data_o   = 32'h0;
        flush_o           = 1'b0;
        redirect_valid_o  = 1'b0;
        redirect_pc_o     = 32'h0;
        if (!rst_i) begin
            flush_o = (state_q != S_IDLE);
            case (state_q)
                S_IDLE: req_ready_o = 1'b1;
                S_W_EPC: begin
                    rm_write_enable_o = 1'b1;
                    rm_write_addr_o   = ADDR_MEPC;
                    rm_write_data_o   = pc_q & ALIGN_MASK;
                end
                S_W_CAUSE: begin
                    rm_write_enable_o = 1'b1;
                    rm_write_addr_o   = ADDR_MCAUSE;
                    rm_write_data_o   = cause_q;
                end
                S_W_TVAL: begin
                    rm_write_enable_o = 1'b1;
                    rm_write_addr_o   = ADDR_MTVAL;
                    rm_write_data_o   = tval_q;
                end
                S_W_PRIV: begin
                    rm_write_enable_o = 1'b1;
                    rm_write_addr_o   = ADDR_PRIV;
                    rm_write_data_o   = PRIV_MACHINE;
                end
                S_M_PRIV: begin
                    rm_write_enable_o = 1'b1;
                    rm_write_addr_o   = ADDR_PRIV;
                    rm_write_data_o   = PRIV_USER;
                end
                S_REDIRECT: begin
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = target_q;
                end
                default: begin
                    req_ready_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_csr_writer.sv
// tb/tb_trap_csr_writer.sv - scoreboard bench for trap_csr_writer
module tb_trap_csr_writer;

    localparam logic [31:0] TRAP_VEC = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        exc_valid_i = 1'b0;
    logic [31:0] exc_pc_i = 32'h0;
    logic [31:0] exc_cause_i = 32'h0;
    logic [31:0] exc_tval_i = 32'h0;
    logic        mret_valid_i = 1'b0;
    logic        req_ready_o;
    logic        rm_write_enable_o;
    logic [1:0]  rm_write_addr_o;
    logic [31:0] rm_write_data_o;
    logic [1:0]  rm_read_addr_o;
    logic [31:0] rm_read_data_i;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    trap_csr_writer #(.TRAP_VECTOR(TRAP_VEC)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .exc_valid_i       (exc_valid_i),
        .exc_pc_i          (exc_pc_i),
        .exc_cause_i       (exc_cause_i),
        .exc_tval_i        (exc_tval_i),
        .mret_valid_i      (mret_valid_i),
        .req_ready_o       (req_ready_o),
        .rm_write_enable_o (rm_write_enable_o),
        .rm_write_addr_o   (rm_write_addr_o),
        .rm_write_data_o   (rm_write_data_o),
        .rm_read_addr_o    (rm_read_addr_o),
        .rm_read_data_i    (rm_read_data_i),
        .flush_o           (flush_o),
        .redirect_valid_o  (redirect_valid_o),
        .redirect_pc_o     (redirect_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_redirect;
        logic [1:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   edge_cnt = 0;
    int   busy_from = 1;
    int   busy_to = 0;
    int   tests = 0;
    int   failed = 0;

    logic [31:0] rf [4];
    logic        pre_en = 1'b0;
    logic [31:0] pre_val = 32'h0;

    // Register file model: commits on the edge ending the write cycle.
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (rst_i && edge_cnt < 3) begin
            for (int i = 0; i < 4; i++) rf[i] <= 32'h0;
        end else if (rm_write_enable_o) begin
            rf[rm_write_addr_o] <= rm_write_data_o;
        end else if (pre_en) begin
            rf[0] <= pre_val;
        end
    end
    assign rm_read_data_i = rf[rm_read_addr_o];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, edge_cnt + 1);
        end
    endtask

    task automatic push(input bit is_rd, input logic [1:0] addr, input logic [31:0] data, input int cyc);
        exp_t e;
        e.is_redirect = is_rd;
        e.addr = addr;
        e.data = data;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    // Monitor: cycle k is the period between edge k-1 and edge k.
    always @(negedge clk) begin : monitor
        int   cur;
        bit   busy;
        exp_t e;
        cur = edge_cnt + 1;
        busy = (cur >= busy_from) && (cur <= busy_to);
        if (rst_i) begin
            check("reset_outputs_zero",
                  {31'b0, |{req_ready_o, rm_write_enable_o, rm_write_addr_o, rm_write_data_o,
                            rm_read_addr_o, flush_o, redirect_valid_o, redirect_pc_o}}, 32'h0);
        end else begin
            check("flush", {31'b0, flush_o}, {31'b0, busy});
            check("req_ready", {31'b0, req_ready_o}, {31'b0, !busy});
            check("read_addr", {30'b0, rm_read_addr_o}, 32'h0);
            if (!rm_write_enable_o)
                check("idle_write_bus", {31'b0, |{rm_write_addr_o, rm_write_data_o}}, 32'h0);
            if (rm_write_enable_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {30'b0, rm_write_addr_o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("write_kind", {31'b0, e.is_redirect}, 32'h0);
                    check("write_cycle", cur, e.cyc);
                    check("write_addr", {30'b0, rm_write_addr_o}, {30'b0, e.addr});
                    check("write_data", rm_write_data_o, e.data);
                end
            end
            if (redirect_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_redirect", redirect_pc_o, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("redirect_kind", {31'b0, e.is_redirect}, 32'h1);
                    check("redirect_cycle", cur, e.cyc);
                    check("redirect_pc", redirect_pc_o, e.data);
                end
            end
        end
    end

    task automatic issue_exc(input logic [31:0] pc, input logic [31:0] cause,
                             input logic [31:0] tval, output int n);
        exc_pc_i = pc;
        exc_cause_i = cause;
        exc_tval_i = tval;
        exc_valid_i = 1'b1;
        n = -1;
        for (int i = 0; i < 30 && n < 0; i++) begin
            @(negedge clk);
            if (req_ready_o) n = edge_cnt + 1;
        end
        if (n < 0) begin
            check("exc_accept_timeout", 32'h0, 32'h1);
            n = 0;
        end else begin
            push(1'b0, 2'b00, pc & 32'hFFFF_FFFC, n + 1);
            push(1'b0, 2'b01, cause, n + 2);
            push(1'b0, 2'b10, tval, n + 3);
            push(1'b0, 2'b11, 32'h1, n + 4);
            push(1'b1, 2'b00, TRAP_VEC, n + 5);
            busy_from = n + 1;
            busy_to = n + 5;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue_mret(input logic [31:0] exp_epc, output int n);
        mret_valid_i = 1'b1;
        n = -1;
        for (int i = 0; i < 30 && n < 0; i++) begin
            @(negedge clk);
            if (req_ready_o) n = edge_cnt + 1;
        end
        if (n < 0) begin
            check("mret_accept_timeout", 32'h0, 32'h1);
            n = 0;
        end else begin
            push(1'b0, 2'b11, 32'h0, n + 2);
            push(1'b1, 2'b00, exp_epc, n + 3);
            busy_from = n + 1;
            busy_to = n + 3;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        int n;
        int n2;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic exception entry.
        issue_exc(32'h0000_1006, 32'h2, 32'hDEAD_BEEF, n);
        exc_valid_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // mret with a misaligned saved mepc.
        pre_val = 32'h0000_0103;
        pre_en = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
        issue_mret(32'h0000_0100, n);
        mret_valid_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Simultaneous requests: exception first, then the held mret reads the new mepc.
        mret_valid_i = 1'b1;
        issue_exc(32'h0000_300B, 32'h5, 32'h0000_1234, n);
        exc_valid_i = 1'b0;
        issue_mret(32'h0000_3008, n2);
        mret_valid_i = 1'b0;
        check("mret_after_exc_accept", n2, n + 6);
        repeat (6) @(posedge clk);
        #1;

        // Exception pulse while busy in W_CAUSE is ignored.
        issue_exc(32'h0000_4000, 32'h7, 32'h0, n);
        exc_valid_i = 1'b0;
        @(posedge clk);
        #1;
        exc_pc_i = 32'hFFFF_FFFF;
        exc_cause_i = 32'hFFFF_FFFF;
        exc_valid_i = 1'b1;
        @(posedge clk);
        #1 exc_valid_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Reset during W_TVAL aborts the sequence.
        issue_exc(32'h0000_5000, 32'h3, 32'h0000_ABCD, n);
        exc_valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_i = 1'b1;
        while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc >= n + 3)
            exp_q.delete(exp_q.size() - 1);
        busy_to = n + 2;
        @(posedge clk);
        #1 rst_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Back-to-back exceptions with valid held.
        issue_exc(32'h0000_6000, 32'hB, 32'h0000_6000, n);
        issue_exc(32'h0000_7004, 32'hC, 32'h0000_7004, n2);
        exc_valid_i = 1'b0;
        check("back_to_back_accept", n2, n + 6);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
